// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store ports onto one single-port memory, with an in-order ID queue
// routing read responses back. Define ARB_RR_EN for round-robin instead of data-priority+starve.
module mem_arbiter #(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned MAX_OUT      = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          err
);
    localparam int unsigned PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned CW = $clog2(MAX_OUT + 1);
    localparam logic [PW-1:0] ptr_max = PW'(MAX_OUT - 1);
    localparam logic [CW-1:0] count_full = CW'(MAX_OUT);

    logic [MAX_OUT-1:0] id_q;
    logic [PW-1:0]      rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]      count_q;
    logic               err_q;
    logic               blocked, fetch_pri, sel_if, sel_d;
    logic               push, pop, head;

`ifdef ARB_RR_EN
    logic last_q;  // 1 = data won last grant
`else
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] starve_max = SW'(STARVE_LIMIT);
    logic [SW-1:0] starve_q;
`endif

    always_comb begin
        blocked = (count_q == count_full);
`ifdef ARB_RR_EN
        fetch_pri = last_q;
`else
        fetch_pri = (starve_q >= starve_max);
`endif
        sel_if = !blocked && if_req && (!d_req || fetch_pri);
        sel_d  = !blocked && d_req && !sel_if;

        mem_req   = sel_if | sel_d;
        mem_we    = sel_d & d_we;
        mem_addr  = sel_if ? if_addr : (sel_d ? d_addr : '0);
        mem_wdata = sel_d ? d_wdata : '0;
        if_gnt    = sel_if & mem_gnt;
        d_gnt     = sel_d & mem_gnt;

        head      = id_q[rd_ptr_q];
        pop       = mem_rvalid && (count_q != '0);
        if_rvalid = pop & ~head;
        d_rvalid  = pop & head;
        rdata     = mem_rdata;
        push      = if_gnt | (d_gnt & ~d_we);
        err       = err_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_q     <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
`ifdef ARB_RR_EN
            last_q   <= 1'b1;
`else
            starve_q <= '0;
`endif
        end else begin
            if (push) begin
                id_q[wr_ptr_q] <= d_gnt;
                wr_ptr_q       <= (wr_ptr_q == ptr_max) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == ptr_max) ? '0 : rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
            if (mem_rvalid && count_q == '0) begin
                err_q <= 1'b1;
            end
`ifdef ARB_RR_EN
            if (if_gnt || d_gnt) begin
                last_q <= d_gnt;
            end
`else
            if (if_req && !if_gnt) begin
                starve_q <= (starve_q == starve_max) ? starve_q : starve_q + SW'(1);
            end else begin
                starve_q <= '0;
            end
`endif
        end
    end
endmodule
